// File: rtl/regfile_wr_arbiter.sv
// Purpose: share the regfile write port; pipeline writeback wins, LU results queue (guard: REGFILE_ARB_STARVE_GUARD_EN).
// Latency: wb request -> rf_we next cycle; LU accept -> rf_we two cycles later at the earliest.
// Backpressure: wb never held except one-cycle wb_stall from the guard; LU held off by lu_ready when FIFO full.
module regfile_wr_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        haz1,
  output logic        haz2,
  output logic        wb_stall,
  output logic        proto_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Ring-buffer pointers wrap for free, so DEPTH has to be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_cfg
    $error("regfile_wr_arbiter: DEPTH must be a power of two >= 2, STARVE_MAX in 1..255");
  end

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t       ent_q [DEPTH];
  wr_req_t       ent_d [DEPTH];
  logic [PW-1:0] ent_off [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic          wb_req;
  logic          fifo_empty;
  logic          lu_fire;
  logic          enq;
  logic          deq;

  // A write to x0 is architecturally a no-op, so it never claims the port.
  assign wb_req     = wb_we & (wb_addr != 5'd0);
  assign fifo_empty = (count_q == '0);

  // Port arbitration: pipeline first, then FIFO head; an idle port keeps the last address/data.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    deq       = 1'b0;
    if (wb_req) begin
      rf_we_d   = 1'b1;
      rf_addr_d = wb_addr;
      rf_data_d = wb_data;
    end else if (!fifo_empty) begin
      rf_we_d   = 1'b1;
      rf_addr_d = ent_q[rd_ptr_q].addr;
      rf_data_d = ent_q[rd_ptr_q].data;
      deq       = 1'b1;
    end
  end

  // FIFO push/pop bookkeeping; ready comes only from registered count, no full-and-pop pass-through.
  always_comb begin
    lu_ready = ~rst & (count_q != FULL_CNT);
    lu_fire  = lu_valid & lu_ready;
    // x0 results are accepted to free the unit but dropped here.
    enq      = lu_fire & (lu_addr != 5'd0);
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      ent_d[wr_ptr_q] = '{addr: lu_addr, data: lu_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    ent_off = '{default: '0};
    ent_vld = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_off[i] = PW'(i) - rd_ptr_q;
      ent_vld[i] = ({1'b0, ent_off[i]} < count_q);
    end
  end

  // Hazards see registered contents only: same-cycle pushes are invisible, the head being popped still counts.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_vld[i] && (rd_addr1 != 5'd0) && (ent_q[i].addr == rd_addr1)) begin
        haz1 = 1'b1;
      end
      if (ent_vld[i] && (rd_addr2 != 5'd0) && (ent_q[i].addr == rd_addr2)) begin
        haz2 = 1'b1;
      end
    end
  end

  // Control state; reset drops every pending entry by zeroing the occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage needs no reset: nothing reads an entry outside the live window.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_q, starve_d;
  logic       wb_stall_q, wb_stall_d;
  logic       proto_err_q, proto_err_d;

  // Count cycles the pipeline beats a waiting head; a pop, an empty FIFO or the guard cycle restart it.
  always_comb begin
    starve_d = starve_q;
    if (wb_stall_q || deq || fifo_empty) begin
      starve_d = 8'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 8'd1;
    end
    // The counter clears in the stall cycle, so this fires for exactly one cycle.
    wb_stall_d  = (starve_d == STARVE_LIM);
    proto_err_d = proto_err_q | (wb_stall_q & wb_we);
  end

  // Guard state; proto_err is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= 8'd0;
      wb_stall_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      wb_stall_q  <= wb_stall_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign wb_stall  = wb_stall_q;
  assign proto_err = proto_err_q;
`else
  // Without the guard the FIFO only drains in cycles the pipeline leaves free.
  assign wb_stall  = 1'b0;
  assign proto_err = 1'b0;
`endif

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port of the 32x32 register file between the in-order pipeline writeback and a long-latency unit (multiply/divide, load-return) that completes out of band. Pipeline writeback always has priority. Long-latency results are buffered in a small FIFO and drained into idle write slots. The block also reports read-after-write hazards against pending buffered writes so decode can stall.

## Interface
Parameters:
- DEPTH, 4: pending-write FIFO entries (power of two, ≥2)
- STARVE_MAX, 8: consecutive lost arbitration cycles before the guard engages (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- wb_we  in  1  pipeline writeback request, never back-pressured
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- lu_valid  in  1  long-latency unit write request
- lu_ready  out  1  FIFO can accept; transfer when lu_valid & lu_ready
- lu_addr  in  5  long-latency destination register
- lu_data  in  32  long-latency write data
- rf_we  out  1  register file write enable (registered)
- rf_addr  out  5  register file write address (registered)
- rf_data  out  32  register file write data (registered)
- rd_addr1, rd_addr2  in  5 each  decode read addresses
- haz1, haz2  out  1 each  read address matches a pending FIFO entry
- wb_stall  out  1  guard request: pipeline must hold wb_we=0 this cycle
- proto_err  out  1  sticky: wb_we seen while wb_stall=1

## Operation
- Reset values: rf_we=0, rf_addr=0, rf_data=0, wb_stall=0, proto_err=0, FIFO empty, starvation counter=0. lu_ready=0 while rst=1.
- lu_ready = ~rst & (count != DEPTH). Combinational from registered count. No same-cycle full-and-dequeue pass-through.
- Accepted lu transfer with lu_addr=0: consumed, not enqueued, never written.
- Arbitration each cycle, in priority order:
  1. wb_we=1 with wb_addr≠0: rf_* load the wb request.
  2. Otherwise, if the FIFO is non-empty: pop the head into rf_*.
  3. Otherwise: rf_we=0. rf_addr and rf_data hold their previous values.
- wb_we=1 with wb_addr=0: treated as no request, so the FIFO may drain that cycle.
- Enqueue and dequeue in the same cycle are permitted. count is unchanged.
- haz1/haz2: combinational. High when rd_addrN≠0 and it equals the address of any valid FIFO entry. An entry enqueuing this cycle is not yet counted; the entry being popped this cycle is still counted.
- Contract (enforced by decode using haz1/haz2, not checked here): the pipeline never writes an address that is pending in the FIFO.
- Ordering: FIFO entries retire strictly in acceptance order.

## Timing
- Pipeline write: wb_we in cycle t produces rf_we=1 in cycle t+1. The register file commits at the end of t+1.
- Long-latency write: accepted in cycle t, head eligible in t+1, so rf_we=1 at earliest in t+2.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and a pipeline write wins.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Guard:
  - wb_stall is registered. It asserts in the cycle after the counter reaches STARVE_MAX and stays high for exactly one cycle.
  - In that cycle the FIFO head is popped and the counter clears.
  - If wb_we=1 anyway, the pipeline still wins and proto_err sets (cleared only by rst).
- Reset mid-operation: all pending FIFO entries are discarded. rf_we=0 in the cycle after rst is sampled high.

## Configuration
- REGFILE_ARB_STARVE_GUARD_EN defined: starvation counter, wb_stall and proto_err behave as specified above.
- Not defined:
  - No counter logic.
  - wb_stall and proto_err are tied to 0.
  - The FIFO drains only in cycles without a pipeline write.

## Test plan
- Reset, then wb_we=1, addr=5, data=0xDEADBEEF: rf_we=1, rf_addr=5, rf_data=0xDEADBEEF exactly one cycle later. rf_we=0 before that.
- lu write addr=7, data=0x12345678 with wb idle: rf_we=1, rf_addr=7 two cycles after acceptance. haz1=1 for rd_addr1=7 while pending, 0 afterwards.
- wb_we=1 every cycle while 5 lu writes are offered (guard macro off): lu_ready drops after 4 accepts. Once wb stops, entries drain in acceptance order, one per cycle.
- Guard on, STARVE_MAX=8, one FIFO entry, wb_we=1 continuously: wb_stall=1 for one cycle after 8 lost cycles. Holding wb_we=1 during it sets proto_err=1. Dropping wb_we pops the head.
- wb_we=1 with addr=0 and lu write with addr=0: no rf_we pulse. The FIFO count is unchanged by the lu write, and a pending entry drains in the wb addr=0 cycle.
- rst asserted with 3 entries pending: lu_ready=0 during reset. After reset, count=0, haz1/haz2=0, and no rf_we pulses occur.
